// File: rtl/mem_sched_pkg.sv
// Shared types and defaults for the memory port scheduler: FSM state encoding,
// default address/data widths and the requester command record.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 24;

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of mask at or after ptr,
// wrapping modulo N. Returns one-hot, index and a found flag.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && mask[PW'(j)]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign onehot[gi] = found && (idx == PW'(gi));
  end

endmodule

// File: rtl/mem_port_sched.sv
// Shares a single-port synchronous memory between NREQ requesters with
// round-robin arbitration. Optional MEM_SCHED_REQ0_PRIO_EN: requester 0 has fixed priority.
module mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  state_t          state_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [NREQ-1:0] elig, arb_mask, arb_onehot, win_onehot;
  logic [PW-1:0]   arb_idx, win_idx;
  logic            arb_found, win_found, win_upd_ptr;

  // done is high only in RESP, so this excludes the finishing requester there
  assign elig = req & ~done;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .mask   (arb_mask),
    .ptr    (rr_ptr_reg),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .found  (arb_found)
  );

`ifdef MEM_SCHED_REQ0_PRIO_EN
  assign arb_mask = elig & ~NREQ'(1);
  always_comb begin
    win_onehot  = arb_onehot;
    win_idx     = arb_idx;
    win_found   = arb_found;
    win_upd_ptr = 1'b1;
    if (elig[0]) begin
      win_onehot  = NREQ'(1);
      win_idx     = '0;
      win_found   = 1'b1;
      win_upd_ptr = 1'b0;
    end
  end
`else
  assign arb_mask    = elig;
  assign win_onehot  = arb_onehot;
  assign win_idx     = arb_idx;
  assign win_found   = arb_found;
  assign win_upd_ptr = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      gnt        <= '0;
      done       <= '0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      done <= '0;
      case (state_reg)
        IDLE, RESP: begin
          if (win_found) begin
            // the memory command registers double as the captured command
            state_reg <= ACCESS;
            busy      <= 1'b1;
            gnt       <= win_onehot;
            mem_en    <= 1'b1;
            mem_we    <= req_we[win_idx];
            mem_addr  <= req_addr[win_idx*AW +: AW];
            mem_wdata <= req_wdata[win_idx*DW +: DW];
            if (win_upd_ptr)
              rr_ptr_reg <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        ACCESS: begin
          state_reg <= RESP;
          gnt       <= '0;
          done      <= gnt;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          if (!mem_we) rdata <= mem_rdata;
        end
        default: begin
          state_reg <= IDLE;
          gnt       <= '0;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
